pe_mac_drain: RTL and testbench
===============================

# pe_mac_drain

Parametrised systolic processing element: the successor to the current 8-bit MAC PE, sitting at each (row, column) node of the systolic array. Operands pass east/south unchanged, and the PE accumulates a signed or unsigned dot product. A completed result is double-buffered so the next tile can compute while the previous one drains. Results drain down the column over a valid/ready chain with a local FIFO and a guaranteed local-then-upstream emission order.

## Interface
- D_W, 8, operand width
- ACC_W, 2*D_W+4, accumulator and drain-data width (≥ 2*D_W)
- SIGNED, 0, 1 = two's-complement operands, products sign-extended to ACC_W
- FIFO_DEPTH, 4, pass-through FIFO entries (power of two, ≥ 2)
- UP_CNT, 0, number of PEs upstream in this column (results forwarded per tile)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_a / in_b  in  D_W  operands from west / north
- in_en  in  1  operand beat valid
- init  in  1  with in_en: first beat of a new tile
- flush  in  1  close current tile without starting a new one
- out_a / out_b  out  D_W  registered in_a / in_b
- out_en  out  1  registered in_en
- in_data  in  ACC_W  upstream drain data
- in_valid  in  1  upstream data valid
- in_ready  out  1  FIFO not full
- out_data  out  ACC_W  drain data to downstream
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream accepts
- err_ovr  out  1  sticky: a completed result was discarded
- err_sat  out  1  sticky: saturation occurred (tied 0 without macro)

## Operation
- Operand path: out_a, out_b, out_en are registered copies of the inputs every cycle; they are never stalled.
- S1: P = in_a*in_b (2*D_W, signedness per SIGNED), registered with en, init, flush.
- S2, en&init: if acc_live, acc moves to res and res_full = 1; then acc = ext(P) and acc_live = 1.
- S2, en&!init: acc = acc + ext(P), wrapping modulo 2^ACC_W.
- S2, flush (en = 0): if acc_live, acc moves to res and acc_live = 0.
- S2, neither: hold.
- Overrun: a completion while res_full = 1 and res is not being taken that cycle discards the new result, keeps the older res, and sets err_ovr.
- FIFO:
  - Write on in_valid & in_ready.
  - in_ready = !full. It is low when full even if a pop occurs that cycle.
- Drain FSM, state LOCAL:
  - Load the output register from res when res_full; clear res_full.
  - Go to FWD if UP_CNT > 0, else stay in LOCAL.
- Drain FSM, state FWD:
  - Load the output register from the FIFO head when FIFO is non-empty; fwd_cnt++.
  - Return to LOCAL when fwd_cnt reaches UP_CNT; clear fwd_cnt.
- The output register loads only when !out_valid | out_ready.

## Timing
- Reset: out_a, out_b, out_en, out_data, out_valid, err_ovr, err_sat = 0.
- Reset: in_ready = 1, FIFO empty, acc_live = 0, res_full = 0, state LOCAL, fwd_cnt = 0.
- rst_n low mid-operation clears everything at once and discards in-flight results.
- Operands: 1-cycle latency, in to out_a/out_b.
- Completion: an init/flush beat at cycle t makes res_full visible at t+2.
- Emission: out_valid rises at t+3 if the output register is free and the FSM is in LOCAL.
- Throughput: one drain word per cycle while out_ready = 1.
- out_data and out_valid hold stable while out_valid & !out_ready.
- Push to a full FIFO is not accepted because in_ready = 0; no loss.

## Configuration
- PE_SAT_EN defined: S2 accumulation clamps to the ACC_W range and sets err_sat on clamp.
  - Signed range: [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Unsigned range: [0, 2^ACC_W-1].
  - init-loaded values never clamp.
- PE_SAT_EN undefined: accumulation wraps and err_sat is constant 0.

## Test plan
- Basic tile, UP_CNT=0, unsigned:
  - Stimulus: init (3,4), then beats (5,6), (2,7), then flush.
  - Response: one out_data = 56, out_valid 3 cycles after the flush beat; out_a/out_b track the inputs 1 cycle late.
- Signed, SIGNED=1, D_W=8, ACC_W=20:
  - Stimulus: init (0xFD,5), then beat (2,0xFC), then flush.
  - Response: out_data = 0xFFFE9 (-23).
- Ordering, UP_CNT=2:
  - Stimulus: upstream pushes 100, 101 before the local result 7 is ready; two tiles.
  - Response: drain order 7, 100, 101, then tile-2 local value before any tile-2 upstream data.
- Backpressure, FIFO_DEPTH=4:
  - Stimulus: out_ready = 0 for 12 cycles; in_valid pushes 6 words 1..6.
  - Response: in_ready drops after 4 accepts; once out_ready = 1, all 6 exit in order with no duplicates.
- Overrun:
  - Stimulus: out_ready = 0; tiles with results 10, 20, 30, then flush.
  - Response: err_ovr = 1 on the third completion; after release, out_data shows 10 then 20 (one word is held in the output register and one in res); the tile-3 result 30 is discarded.
- Saturation, ACC_W=16, unsigned:
  - Stimulus: init (255,255), then (255,255), then flush.
  - Response: out_data = 65535 and err_sat = 1 with PE_SAT_EN; out_data = 64514 and err_sat = 0 without it.

Source files
------------

// File: rtl/pe_mac_drain.sv
// Systolic MAC processing element: operand forwarding, double-buffered result, ordered column drain.
// Optional macro PE_SAT_EN: saturating accumulation with sticky err_sat (wrapping accumulation otherwise).
module pe_mac_drain #(
  parameter int D_W        = 8,
  parameter int ACC_W      = 2*D_W+4,
  parameter int SIGNED     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int UP_CNT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [D_W-1:0]   in_a,
  input  logic [D_W-1:0]   in_b,
  input  logic             in_en,
  input  logic             init,
  input  logic             flush,
  output logic [D_W-1:0]   out_a,
  output logic [D_W-1:0]   out_b,
  output logic             out_en,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_ovr,
  output logic             err_sat
);

  localparam int P_W   = 2*D_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (UP_CNT > 1) ? $clog2(UP_CNT) : 1;
  localparam logic [CNT_W-1:0] FWD_LAST = CNT_W'((UP_CNT > 0) ? UP_CNT-1 : 0);

  typedef enum logic {ST_LOCAL, ST_FWD} drain_state_t;

  function automatic logic [P_W-1:0] mul_op(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
    logic [P_W-1:0] ea;
    logic [P_W-1:0] eb;
    if (SIGNED != 0) begin
      ea = {{D_W{a[D_W-1]}}, a};
      eb = {{D_W{b[D_W-1]}}, b};
    end else begin
      ea = {{D_W{1'b0}}, a};
      eb = {{D_W{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  function automatic logic [ACC_W-1:0] ext_prod(input logic [P_W-1:0] p);
    logic [ACC_W-1:0] r;
    if (SIGNED != 0) r = ACC_W'($signed(p));
    else             r = ACC_W'(p);
    return r;
  endfunction

`ifdef PE_SAT_EN
  // Returns {clamped, value}; clamps to the ACC_W range of the configured signedness.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] p);
    logic [ACC_W:0] s;
    if (SIGNED != 0) begin
      s = {a[ACC_W-1], a} + {p[ACC_W-1], p};
      if (s[ACC_W] != s[ACC_W-1])
        return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    end else begin
      s = {1'b0, a} + {1'b0, p};
      if (s[ACC_W])
        return {1'b1, {ACC_W{1'b1}}};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction
`else
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] p);
    return a + p;
  endfunction
`endif

  // Operand forwarding: never stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a  <= '0;
      out_b  <= '0;
      out_en <= 1'b0;
    end else begin
      out_a  <= in_a;
      out_b  <= in_b;
      out_en <= in_en;
    end
  end

  // Stage p1: product with beat controls
  logic [P_W-1:0]   prod_p1;
  logic             vld_p1, init_p1, flush_p1;
  logic [ACC_W-1:0] acc, res;
  logic             acc_live, res_full;
  logic             res_take;
  logic [ACC_W-1:0] sum_c;
  logic             complete, accept_res;

`ifdef PE_SAT_EN
  logic [ACC_W:0] add_c;
  logic           sat_hit;
  assign add_c   = acc_add(acc, ext_prod(prod_p1));
  assign sum_c   = add_c[ACC_W-1:0];
  assign sat_hit = add_c[ACC_W];
`else
  assign sum_c = acc_add(acc, ext_prod(prod_p1));
`endif

  // A completion is dropped only when res still holds an untaken word.
  assign complete   = acc_live & (vld_p1 ? init_p1 : flush_p1);
  assign accept_res = complete & (!res_full | res_take);

  always_ff @(posedge clk) begin
    prod_p1 <= mul_op(in_a, in_b);
    if (vld_p1)
      acc <= init_p1 ? ext_prod(prod_p1) : sum_c;
    if (accept_res)
      res <= acc;
  end

  // Stage p2: accumulator / result-buffer control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      init_p1  <= 1'b0;
      flush_p1 <= 1'b0;
      acc_live <= 1'b0;
      res_full <= 1'b0;
      err_ovr  <= 1'b0;
    end else begin
      vld_p1   <= in_en;
      init_p1  <= init;
      flush_p1 <= flush;
      if (vld_p1 & init_p1)
        acc_live <= 1'b1;
      else if (!vld_p1 & flush_p1)
        acc_live <= 1'b0;
      if (accept_res)
        res_full <= 1'b1;
      else if (res_take)
        res_full <= 1'b0;
      if (complete & !accept_res)
        err_ovr <= 1'b1;
    end
  end

`ifdef PE_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sat <= 1'b0;
    else if (vld_p1 & !init_p1 & sat_hit)
      err_sat <= 1'b1;
  end
`else
  assign err_sat = 1'b0;
`endif

  // Upstream pass-through FIFO
  logic [ACC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [ACC_W-1:0] fifo_head;

  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign in_ready   = !fifo_full;
  assign fifo_head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (in_valid & in_ready)
      mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (in_valid & in_ready)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (fifo_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Drain sequencer: local word first, then UP_CNT upstream words
  drain_state_t     state, state_n;
  logic [CNT_W-1:0] fwd_cnt, fwd_cnt_n;
  logic             load, can_load;
  logic [ACC_W-1:0] load_data;

  assign can_load = !out_valid | out_ready;

  always_comb begin
    state_n   = state;
    fwd_cnt_n = fwd_cnt;
    res_take  = 1'b0;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    load_data = res;
    case (state)
      ST_LOCAL: begin
        if (res_full & can_load) begin
          res_take = 1'b1;
          load     = 1'b1;
          if (UP_CNT > 0)
            state_n = ST_FWD;
        end
      end
      ST_FWD: begin
        if (!fifo_empty & can_load) begin
          fifo_pop  = 1'b1;
          load      = 1'b1;
          load_data = fifo_head;
          if (fwd_cnt == FWD_LAST) begin
            state_n   = ST_LOCAL;
            fwd_cnt_n = '0;
          end else begin
            fwd_cnt_n = fwd_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_LOCAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOCAL;
      fwd_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state   <= state_n;
      fwd_cnt <= fwd_cnt_n;
      if (load) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_drain.sv
// Bench for pe_mac_drain: three configurations (unsigned 16-bit acc, signed 20-bit acc, UP_CNT=2 drain chain).
// Expectations follow PE_SAT_EN when defined.
module tb_pe_mac_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PE_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic       rst_n;
  logic [7:0] in_a, in_b;
  logic       in_en, init, flush, out_ready;

  logic [7:0]  ua_oa, ua_ob, us_oa, us_ob, uo_oa, uo_ob;
  logic        ua_oe, us_oe, uo_oe;
  logic [15:0] ua_od;
  logic [19:0] us_od, uo_od, uo_id;
  logic        ua_ov, ua_ir, ua_eo, ua_es;
  logic        us_ov, us_ir, us_eo, us_es;
  logic        uo_ov, uo_ir, uo_iv, uo_eo, uo_es;

  pe_mac_drain #(.D_W(8), .ACC_W(16), .SIGNED(0), .FIFO_DEPTH(4), .UP_CNT(0)) ua (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_en(in_en), .init(init), .flush(flush),
    .out_a(ua_oa), .out_b(ua_ob), .out_en(ua_oe), .in_data(16'd0), .in_valid(1'b0), .in_ready(ua_ir),
    .out_data(ua_od), .out_valid(ua_ov), .out_ready(out_ready), .err_ovr(ua_eo), .err_sat(ua_es));

  pe_mac_drain #(.D_W(8), .ACC_W(20), .SIGNED(1), .FIFO_DEPTH(4), .UP_CNT(0)) us (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_en(in_en), .init(init), .flush(flush),
    .out_a(us_oa), .out_b(us_ob), .out_en(us_oe), .in_data(20'd0), .in_valid(1'b0), .in_ready(us_ir),
    .out_data(us_od), .out_valid(us_ov), .out_ready(out_ready), .err_ovr(us_eo), .err_sat(us_es));

  pe_mac_drain #(.D_W(8), .ACC_W(20), .SIGNED(0), .FIFO_DEPTH(4), .UP_CNT(2)) uo (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_en(in_en), .init(init), .flush(flush),
    .out_a(uo_oa), .out_b(uo_ob), .out_en(uo_oe), .in_data(uo_id), .in_valid(uo_iv), .in_ready(uo_ir),
    .out_data(uo_od), .out_valid(uo_ov), .out_ready(out_ready), .err_ovr(uo_eo), .err_sat(uo_es));

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  typedef struct {
    int              n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [15:0]     exp_sum;
    logic            exp_sat;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic en, input logic ini, input logic fl);
    in_a = a; in_b = b; in_en = en; init = ini; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    in_a = 8'd0; in_b = 8'd0; in_en = 1'b0; init = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    out_ready = 1'b1; uo_iv = 1'b0; uo_id = 20'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_tile(input int n, input logic [3:0][7:0] a, input logic [3:0][7:0] b);
    for (int i = 0; i < n; i++)
      drive(a[i], b[i], 1'b1, (i == 0), 1'b0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle_inputs();
  endtask

  function automatic logic sel_valid(input int sel);
    case (sel)
      0:       return ua_ov;
      1:       return us_ov;
      default: return uo_ov;
    endcase
  endfunction

  function automatic logic [19:0] sel_data(input int sel);
    case (sel)
      0:       return {4'd0, ua_od};
      1:       return us_od;
      default: return uo_od;
    endcase
  endfunction

  task automatic wait_out(input int sel, input bit rnd_ready, output logic [19:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int c = 0; c < 80 && !ok; c++) begin
      @(negedge clk);
      if (sel_valid(sel) && out_ready) begin
        d  = sel_data(sel);
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic expect_word(input int sel, input bit rnd_ready, input logic [19:0] exp, input string name);
    logic [19:0] d;
    bit ok;
    wait_out(sel, rnd_ready, d, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: no output word within budget, expected %0d", name, exp);
    end else begin
      check(name, d, exp);
    end
  endtask

  task automatic expect_quiet(input int sel, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sel_valid(sel)) seen = 1'b1;
    end
    @(posedge clk); #1;
    check(name, seen, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [19:0]     got [$];
    logic [19:0]     exp_q [$];
    logic [3:0][7:0] ta, tb;
    logic [7:0]      ra, rb;
    int              sum, n;

    // ---------------- reset values ----------------
    do_reset();
    @(negedge clk);
    check("rst_out_a", ua_oa, 0);
    check("rst_out_b", ua_ob, 0);
    check("rst_out_en", ua_oe, 0);
    check("rst_out_data", ua_od, 0);
    check("rst_out_valid", ua_ov, 0);
    check("rst_in_ready", ua_ir, 1);
    check("rst_err_ovr", ua_eo, 0);
    check("rst_err_sat", ua_es, 0);
    check("rst_uo_in_ready", uo_ir, 1);
    check("rst_us_valid", us_ov | us_oe | us_eo | us_es | uo_ov | uo_oe | uo_eo | uo_es, 0);
    @(posedge clk); #1;

    // ---------------- basic tile with latency checks ----------------
    in_a = 8'd3; in_b = 8'd4; in_en = 1'b1; init = 1'b1;
    @(posedge clk); #1;
    in_a = 8'd5; in_b = 8'd6; init = 1'b0;
    @(negedge clk);
    check("track_a0", ua_oa, 3);
    check("track_b0", ua_ob, 4);
    check("track_en0", ua_oe, 1);
    @(posedge clk); #1;
    in_a = 8'd2; in_b = 8'd7;
    @(negedge clk);
    check("track_a1", ua_oa, 5);
    check("track_b1", us_ob, 6);
    @(posedge clk); #1;
    in_a = 8'd0; in_b = 8'd0; in_en = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("track_a2", uo_oa, 2);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("track_en_off", ua_oe, 0);
    @(posedge clk);
    @(negedge clk);
    check("emit_not_early", ua_ov, 0);
    @(posedge clk);
    @(negedge clk);
    check("emit_t3_valid", ua_ov, 1);
    check("emit_t3_data", ua_od, 56);
    @(posedge clk); #1;
    @(negedge clk);
    check("emit_single", ua_ov, 0);
    @(posedge clk); #1;

    // ---------------- table-driven tiles (unsigned, ACC_W=16) ----------------
    vecs[0].n = 3; vecs[0].a = {8'd0, 8'd2, 8'd5, 8'd3};     vecs[0].b = {8'd0, 8'd7, 8'd6, 8'd4};
    vecs[0].exp_sum = 16'd56;    vecs[0].exp_sat = 1'b0;
    vecs[1].n = 1; vecs[1].a = {8'd0, 8'd0, 8'd0, 8'd255};   vecs[1].b = {8'd0, 8'd0, 8'd0, 8'd255};
    vecs[1].exp_sum = 16'd65025; vecs[1].exp_sat = 1'b0;
    vecs[2].n = 4; vecs[2].a = {8'd1, 8'd0, 8'd20, 8'd10};   vecs[2].b = {8'd1, 8'd0, 8'd20, 8'd10};
    vecs[2].exp_sum = 16'd501;   vecs[2].exp_sat = 1'b0;
    vecs[3].n = 3; vecs[3].a = {8'd0, 8'd250, 8'd150, 8'd200}; vecs[3].b = {8'd0, 8'd250, 8'd100, 8'd100};
    vecs[3].exp_sum = SAT_ON ? 16'd65535 : 16'd31964; vecs[3].exp_sat = SAT_ON;
    vecs[4].n = 2; vecs[4].a = {8'd0, 8'd0, 8'd255, 8'd255}; vecs[4].b = {8'd0, 8'd0, 8'd255, 8'd255};
    vecs[4].exp_sum = SAT_ON ? 16'd65535 : 16'd64514; vecs[4].exp_sat = SAT_ON;

    for (int i = 0; i < 5; i++) begin
      send_tile(vecs[i].n, vecs[i].a, vecs[i].b);
      expect_word(0, 1'b0, {4'd0, vecs[i].exp_sum}, $sformatf("table_sum[%0d]", i));
      check($sformatf("table_err_sat[%0d]", i), ua_es, vecs[i].exp_sat);
    end
    check("table_err_ovr", ua_eo, 0);

    // ---------------- signed tile ----------------
    do_reset();
    ta = {8'd0, 8'd0, 8'd2, 8'hFD};
    tb = {8'd0, 8'd0, 8'hFC, 8'd5};
    send_tile(2, ta, tb);
    expect_word(1, 1'b0, 20'hFFFE9, "signed_sum");

    // ---------------- reset while a result is in flight ----------------
    do_reset();
    drive(8'd9, 8'd9, 1'b1, 1'b1, 1'b0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_quiet(0, "reset_discards_result");

    // ---------------- randomized signed tiles vs dot-product model ----------------
    do_reset();
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 6);
      sum = 0;
      for (int i = 0; i < n; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        sum += int'($signed(ra)) * int'($signed(rb));
        drive(ra, rb, 1'b1, (i == 0), 1'b0);
        if ($urandom_range(0, 3) == 0)
          drive(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      end
      drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      idle_inputs();
      expect_word(1, 1'b1, 20'(sum), $sformatf("rand_tile[%0d]", t));
    end
    out_ready = 1'b1;
    check("rand_err_ovr", us_eo, 0);

    // ---------------- overrun ----------------
    do_reset();
    out_ready = 1'b0;
    drive(8'd10, 8'd1, 1'b1, 1'b1, 1'b0);
    drive(8'd20, 8'd1, 1'b1, 1'b1, 1'b0);
    drive(8'd30, 8'd1, 1'b1, 1'b1, 1'b0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    @(negedge clk);
    check("ovr_before_third", ua_eo, 0);
    check("ovr_held_valid", ua_ov, 1);
    @(posedge clk);
    @(negedge clk);
    check("ovr_on_third", ua_eo, 1);
    check("ovr_held_data0", ua_od, 10);
    @(posedge clk);
    @(negedge clk);
    check("ovr_held_data1", ua_od, 10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_word(0, 1'b0, 20'd10, "ovr_word0");
    expect_word(0, 1'b0, 20'd20, "ovr_word1");
    expect_quiet(0, "ovr_third_discarded");

    // ---------------- drain ordering, UP_CNT=2 ----------------
    do_reset();
    out_ready = 1'b0;
    uo_iv = 1'b1; uo_id = 20'd100;
    @(posedge clk); #1;
    uo_id = 20'd101;
    @(posedge clk); #1;
    uo_iv = 1'b0;
    drive(8'd7, 8'd1, 1'b1, 1'b1, 1'b0);
    drive(8'd9, 8'd1, 1'b1, 1'b1, 1'b0);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    uo_iv = 1'b1; uo_id = 20'd200;
    @(posedge clk); #1;
    uo_id = 20'd201;
    @(posedge clk); #1;
    uo_iv = 1'b0;
    @(negedge clk);
    check("order_fifo_full", uo_ir, 0);
    check("order_first_held", uo_od, 7);
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_word(2, 1'b0, 20'd7,   "order_w0");
    expect_word(2, 1'b0, 20'd100, "order_w1");
    expect_word(2, 1'b0, 20'd101, "order_w2");
    expect_word(2, 1'b0, 20'd9,   "order_w3");
    expect_word(2, 1'b0, 20'd200, "order_w4");
    expect_word(2, 1'b0, 20'd201, "order_w5");
    expect_quiet(2, "order_no_extra");
    check("order_err_ovr", uo_eo, 0);

    // ---------------- backpressure on the FIFO ----------------
    do_reset();
    out_ready = 1'b0;
    accepts = 0;
    got.delete();
    fork
      begin : pusher
        bit acc;
        for (int w = 1; w <= 6; w++) begin
          uo_id = 20'(w);
          uo_iv = 1'b1;
          acc = 1'b0;
          for (int c = 0; c < 60 && !acc; c++) begin
            @(negedge clk);
            acc = uo_ir;
            @(posedge clk); #1;
          end
          if (!acc) begin
            checks++; errors++;
            $display("FAIL bp_push[%0d]: word not accepted within budget, expected accept", w);
          end else begin
            accepts++;
          end
        end
        uo_iv = 1'b0;
      end
      begin : driver
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("bp_accepts_while_stalled", accepts, 4);
        check("bp_in_ready_low", uo_ir, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
          drive(8'(11 + t), 8'd1, 1'b1, 1'b1, 1'b0);
          drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
          idle_inputs();
          repeat (12) @(posedge clk);
          #1;
        end
      end
      begin : collector
        logic [19:0] d;
        bit ok;
        for (int k = 0; k < 9; k++) begin
          wait_out(2, 1'b0, d, ok);
          if (ok) got.push_back(d);
        end
      end
    join
    exp_q = '{20'd11, 20'd1, 20'd2, 20'd12, 20'd3, 20'd4, 20'd13, 20'd5, 20'd6};
    check("bp_word_count", got.size(), 9);
    for (int k = 0; k < 9; k++)
      check($sformatf("bp_word[%0d]", k), (k < got.size()) ? got[k] : 20'hFFFFF, exp_q[k]);
    expect_quiet(2, "bp_no_duplicates");
    check("bp_err_ovr", uo_eo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
